cpu_reg_file: RTL
=================

Name: cpu_reg_file

Overview:
- Parametrised multi-register successor to the single CPU register: NUM_REGS registers of SIZE bits.
- Two independently selected tristate read ports drive the shared a/b buses.
- One write port loads from the bus.
- A dedicated counter port increments or decrements one register by STEP in place, for SP push/pop and PC advance without an ALU pass.

Parameters:
- SIZE, 32, register width in bits.
- NUM_REGS, 8, number of registers (>=2).
- STEP, 1, increment/decrement amount applied by the counter port (SIZE bits).
- INITIAL_VALS, '0 (NUM_REGS*SIZE bits), packed reset values; register i uses bits [i*SIZE +: SIZE].
- Derived, not overridable: AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- a  out tri  SIZE  read port A bus.
- b  out tri  SIZE  read port B bus.
- sel_a  in  AW  register driven onto a.
- sel_b  in  AW  register driven onto b.
- oe_a  in  1  enable drive on a.
- oe_b  in  1  enable drive on b.
- in  in  SIZE  write data.
- sel_in  in  AW  write target.
- ld  in  1  write strobe.
- sel_cnt  in  AW  counter target.
- inc  in  1  add STEP to reg[sel_cnt].
- dec  in  1  subtract STEP from reg[sel_cnt].
- values  out  NUM_REGS*SIZE  registered contents, packed like INITIAL_VALS; for direct (non-bus) access.

Behaviour:
- Reset: rst==0 at a posedge loads every register from INITIAL_VALS.
  - Reset overrides ld/inc/dec in that cycle.
  - No asynchronous effect.
  - values reflects INITIAL_VALS from the edge after reset is sampled.
- Read ports are combinational.
  - a = oe_a ? reg[sel_a] : 'z; b likewise.
  - Both ports may select the same register.
  - The value shown is the pre-edge content; there is no bypass unless the optional feature is enabled.
- Write: ld==1 at posedge sets reg[sel_in] <= in. Latency one cycle.
- Counter: at posedge, reg[sel_cnt] <= reg[sel_cnt] + STEP if inc&!dec, or − STEP if dec&!inc.
  - Arithmetic is modulo 2^SIZE: max+STEP wraps, 0−STEP wraps.
  - inc&dec together is a no-op.
- Simultaneous ld and counter op:
  - Different targets: both take effect in the same cycle.
  - Same target: ld wins and the count is discarded.
- Out-of-range select (value >= NUM_REGS when NUM_REGS is not a power of two):
  - Writes and counts to it are ignored.
  - An enabled read port drives all zeros (never X).
- No other state; every register holds its value when not addressed.

Optional Feature:
- Macro: CPU_REG_FILE_BYPASS_EN.
- Defined: each read port forwards the next-state value of its selected register in the same cycle.
  - If ld targets it: drives in.
  - Else if a counter op targets it: drives the incremented/decremented result.
  - Same priority as the write logic.
  - Bypass is active only when rst==1.
- Undefined: read ports always show stored content.
- values is never bypassed in either build.

Test Plan:
1. Reset with INITIAL_VALS reg3=0x0000_1000, others 0: hold rst=0 one edge -> values slice 3 = 0x0000_1000; oe_a=1, sel_a=3 -> a=0x0000_1000; oe_a=0 -> a=z.
2. ld=1, sel_in=5, in=0xDEAD_BEEF; the same cycle oe_b=1, sel_b=5 -> b shows old 0 (0xDEAD_BEEF with BYPASS_EN); after the edge, b=0xDEAD_BEEF.
3. STEP=4, reg2=0x0000_0002, dec=1, sel_cnt=2 -> reg2=0xFFFF_FFFE; then inc for 2 cycles -> 0x0000_0006; inc&dec together -> unchanged.
4. ld to reg1 with in=0x55, plus inc on reg1 same cycle -> reg1=0x55; ld reg1=0x55 with inc reg4 (was 7) same cycle -> reg1=0x55, reg4=8.
5. NUM_REGS=6: ld sel_in=7 with in=0x1234 -> no register changes; oe_a=1, sel_a=6 -> a=0.
6. Mid-operation reset: inc active on reg0 for 3 cycles, drop rst=0 on the 4th edge with ld also asserted -> all registers equal INITIAL_VALS; resume with rst=1 -> counting restarts from the initial value.

Source files
------------

// File: rtl/cpu_reg_file.sv
// -----------------------------------------------------------------------------
// cpu_reg_file
//   A file of NUM_REGS registers, each SIZE bits wide, with two tristate read
//   ports, one write port and a counter port. The counter port adds or
//   subtracts STEP in place, so SP push/pop and PC advance need no ALU pass.
//
// Parameters
//   SIZE          register width in bits
//   NUM_REGS      number of registers (>= 2)
//   STEP          amount added or subtracted by the counter port
//   INITIAL_VALS  packed reset values; register i is [i*SIZE +: SIZE]
//   AW            select width, derived from NUM_REGS (not overridable)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-low reset; loads INITIAL_VALS
//   a, b     tristate read buses, driven while oe_a / oe_b is high
//   sel_a    register shown on a
//   sel_b    register shown on b
//   oe_a     drive enable for a
//   oe_b     drive enable for b
//   in       write data
//   sel_in   write target
//   ld       write strobe
//   sel_cnt  counter target
//   inc      add STEP to the counter target
//   dec      subtract STEP from the counter target (inc&dec is a no-op)
//   values   stored contents, packed like INITIAL_VALS, never bypassed
//
// Build option
//   CPU_REG_FILE_BYPASS_EN  when defined, each read port shows the next-state
//                           value of its register (write, then count) while
//                           rst is high. Otherwise, read ports show stored
//                           content.
// -----------------------------------------------------------------------------
module cpu_reg_file #(
    parameter int unsigned               SIZE         = 32,
    parameter int unsigned               NUM_REGS     = 8,
    parameter logic [SIZE-1:0]           STEP         = SIZE'(1),
    parameter logic [NUM_REGS*SIZE-1:0]  INITIAL_VALS = '0,
    localparam int unsigned              AW           = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    output tri   [SIZE-1:0]           a,
    output tri   [SIZE-1:0]           b,
    input  logic [AW-1:0]             sel_a,
    input  logic [AW-1:0]             sel_b,
    input  logic                      oe_a,
    input  logic                      oe_b,
    input  logic [SIZE-1:0]           in,
    input  logic [AW-1:0]             sel_in,
    input  logic                      ld,
    input  logic [AW-1:0]             sel_cnt,
    input  logic                      inc,
    input  logic                      dec,
    output logic [NUM_REGS*SIZE-1:0]  values
);

    logic [SIZE-1:0] regs      [NUM_REGS];
    logic [SIZE-1:0] regs_next [NUM_REGS];
    logic [SIZE-1:0] view      [NUM_REGS];
    logic [SIZE-1:0] rd_a;
    logic [SIZE-1:0] rd_b;
    logic            cnt_up;
    logic            cnt_dn;

    // inc and dec together cancel out
    assign cnt_up = inc & ~dec;
    assign cnt_dn = dec & ~inc;

    // Next-state per register. The select compare is against each legal index,
    // so an out-of-range select matches nothing and changes nothing.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_next[i] = regs[i];
            if (ld && (sel_in == AW'(i))) begin
                regs_next[i] = in;
            end else if (cnt_up && (sel_cnt == AW'(i))) begin
                regs_next[i] = regs[i] + STEP;
            end else if (cnt_dn && (sel_cnt == AW'(i))) begin
                regs_next[i] = regs[i] - STEP;
            end
        end
    end

    // Register state, synchronous active-low reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rst) begin
                regs[i] <= INITIAL_VALS[i*SIZE +: SIZE];
            end else begin
                regs[i] <= regs_next[i];
            end
        end
    end

    // Read-port source: stored content, or forwarded next state
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
`ifdef CPU_REG_FILE_BYPASS_EN
            view[i] = rst ? regs_next[i] : regs[i];
`else
            view[i] = regs[i];
`endif
        end
    end

    // Read muxes; an out-of-range select leaves the zero default
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_a == AW'(i)) begin
                rd_a = view[i];
            end
            if (sel_b == AW'(i)) begin
                rd_b = view[i];
            end
        end
    end

    assign a = oe_a ? rd_a : {SIZE{1'bz}};
    assign b = oe_b ? rd_b : {SIZE{1'bz}};

    // Packed view of stored contents
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_values
        assign values[g*SIZE +: SIZE] = regs[g];
    end

endmodule
